// File: rtl/data_memory_responder_if.sv
// Data-memory port between the CPU datapath (master) and the memory responder (slave).
interface data_memory_responder_if;
   logic [31:0] data_adr;
   logic [31:0] data_out;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] data_in;
   logic        ready;
   logic        err;
   logic        stall;

   modport master (
      output data_adr, data_out, mem_read, mem_write,
      input  data_in, ready, err, stall
   );

   modport slave (
      input  data_adr, data_out, mem_read, mem_write,
      output data_in, ready, err, stall
   );
endinterface

// File: rtl/data_memory_responder.sv
// Word-organised data memory with fixed access latency, one-cycle ready pulse,
// combinational stall for freezing the PC and an error flag for bad addresses.
module data_memory_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   data_memory_responder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   cap_adr;
   logic [31:0]   cap_wdata;
   logic          cap_rd;
   logic          cap_wr;
   logic [31:0]   data_in_q;
   logic          ready_q;
   logic          err_q;
   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx;
   logic          bad;

   // Both strobes at once is treated like a bad address: no access, error reported.
   assign idx = cap_adr[AW+1:2];
   assign bad = (cap_adr[1:0] != 2'b00) | (|cap_adr[31:AW+2]) | (cap_rd & cap_wr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         cap_adr   <= '0;
         cap_wdata <= '0;
         cap_rd    <= 1'b0;
         cap_wr    <= 1'b0;
         data_in_q <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         // NOTE: storage must come out of reset as all zeros, so it is built
         // from resettable flops rather than an inferred RAM macro.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               if (bus.mem_read || bus.mem_write) begin
                  cap_adr   <= bus.data_adr;
                  cap_wdata <= bus.data_out;
                  cap_rd    <= bus.mem_read;
                  cap_wr    <= bus.mem_write;
                  cnt       <= CW'(LATENCY - 1);
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  if (bad) begin
                     data_in_q <= '0;
                     err_q     <= 1'b1;
                  end else begin
                     err_q <= 1'b0;
                     if (cap_rd) begin
                        data_in_q <= mem[idx];
                     end else begin
                        mem[idx] <= cap_wdata;
                     end
                  end
                  ready_q <= 1'b1;
                  state   <= S_RESP;
               end
            end
            S_RESP: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.data_in = data_in_q;
   assign bus.ready   = ready_q;
   assign bus.err     = err_q;
   assign bus.stall   = (bus.mem_read | bus.mem_write) & ~ready_q;
endmodule
